// File: rtl/usb_crc_serializer.sv
// USB transmit serializer: payload LSb-first, then inverted CRC5/CRC16 remainder MSb-first.
// Optional build macro USB_CRC_BACK2BACK_EN lets a new packet load during the final CRC bit.
module usb_crc_serializer #(
    parameter int unsigned MAX_BITS = 64,
    parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    input  logic [MAX_BITS-1:0] pkt_data,
    input  logic [LEN_W-1:0]    pkt_len,
    input  logic                pkt_crc16,
    output logic                bit_out,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                bit_last,
    output logic                busy,
    output logic                done
);

    localparam int unsigned IDX_W = $clog2(MAX_BITS);

    typedef enum logic [1:0] {StIdle, StData, StCrc} state_e;

    state_e              state_q, state_d;
    logic [MAX_BITS-1:0] data_q;
    logic [LEN_W-1:0]    len_q;
    logic                mode_q;
    logic [15:0]         crc_q;
    logic [IDX_W-1:0]    idx_q;
    logic [15:0]         sh_q;
    logic [3:0]          cnt_q;
    logic                done_q;

    logic [LEN_W-1:0]    len_in;
    logic                pkt_fire, bit_fire, data_end, crc_last;
    logic [15:0]         crc_nxt;

    function automatic logic [15:0] crc_preset(input logic m16);
        return m16 ? 16'hFFFF : 16'h001F;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b,
                                             input logic m16);
        logic        fb;
        logic [15:0] nxt;
        if (m16) begin
            fb  = crc[15] ^ b;
            nxt = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end else begin
            fb  = crc[4] ^ b;
            nxt = {11'd0, crc[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
        end
        return nxt;
    endfunction

    // CRC5 remainder is left-aligned so the shifter always emits bit 15.
    function automatic logic [15:0] crc_align(input logic [15:0] crc, input logic m16);
        logic [15:0] inv;
        inv = ~crc;
        return m16 ? inv : {inv[4:0], 11'd0};
    endfunction

    assign len_in   = (pkt_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : pkt_len;
    assign pkt_fire = pkt_valid && pkt_ready;
    assign bit_fire = bit_valid && bit_ready;
    assign data_end = (state_q == StData) && (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign crc_last = (state_q == StCrc) && (cnt_q == 4'd0);
    assign crc_nxt  = crc_step(crc_q, data_q[idx_q], mode_q);
    assign done     = done_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pkt_fire) state_d = (len_in != '0) ? StData : StCrc;
            end
            StData: begin
                if (bit_fire && data_end) state_d = StCrc;
            end
            StCrc: begin
                if (bit_fire && crc_last) begin
                    if (pkt_fire) state_d = (len_in != '0) ? StData : StCrc;
                    else          state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pkt_ready = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        bit_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: pkt_ready = 1'b1;
            StData: begin
                bit_valid = 1'b1;
                bit_out   = data_q[idx_q];
                busy      = 1'b1;
            end
            StCrc: begin
                bit_valid = 1'b1;
                bit_out   = sh_q[15];
                bit_last  = (cnt_q == 4'd0);
                busy      = 1'b1;
`ifdef USB_CRC_BACK2BACK_EN
                pkt_ready = (cnt_q == 4'd0) && bit_ready;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_q <= '0;
            len_q  <= '0;
            mode_q <= 1'b0;
            crc_q  <= 16'hFFFF;
            idx_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= bit_fire && crc_last;
            if (pkt_fire) begin
                data_q <= pkt_data;
                len_q  <= len_in;
                mode_q <= pkt_crc16;
                crc_q  <= crc_preset(pkt_crc16);
                idx_q  <= '0;
                sh_q   <= crc_align(crc_preset(pkt_crc16), pkt_crc16);
                cnt_q  <= pkt_crc16 ? 4'd15 : 4'd4;
            end else if (bit_fire && state_q == StData) begin
                crc_q <= crc_nxt;
                if (data_end) begin
                    sh_q <= crc_align(crc_nxt, mode_q);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else if (bit_fire && state_q == StCrc) begin
                sh_q  <= {sh_q[14:0], 1'b0};
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Scoreboard bench for usb_crc_serializer: stimulus queues expected bits, a monitor pops them.
module tb_usb_crc_serializer;

    localparam int unsigned MAX_BITS = 64;
    localparam int unsigned LEN_W    = $clog2(MAX_BITS + 1);
`ifdef USB_CRC_BACK2BACK_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic                clk, rst_b;
    logic                pkt_valid, pkt_ready, pkt_crc16;
    logic [MAX_BITS-1:0] pkt_data;
    logic [LEN_W-1:0]    pkt_len;
    logic                bit_out, bit_valid, bit_ready, bit_last, busy, done;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   xfer_cnt = 0, done_cnt = 0, busy_cnt = 0, cyc = 0;
    int   last_cyc = 0, gap_cyc = -1, stall_checks = 0;
    bit   after_last = 0, stall_mode = 0, prev_stall = 0;
    logic [2:0] prev_vec;

    usb_crc_serializer #(.MAX_BITS(MAX_BITS)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .pkt_len   (pkt_len),
        .pkt_crc16 (pkt_crc16),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_last  (bit_last),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b, input logic last);
        exp_t e;
        e.b    = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Bit-serial CRC reference, width chosen by mask.
    task automatic model_push(input logic [63:0] d, input int len, input logic m16);
        int          n    = (len > MAX_BITS) ? MAX_BITS : len;
        int          w    = m16 ? 16 : 5;
        logic [15:0] mask = m16 ? 16'hFFFF : 16'h001F;
        logic [15:0] poly = m16 ? 16'h8005 : 16'h0005;
        logic [15:0] c    = mask;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            push_bit(d[i], 1'b0);
            fb = c[w-1] ^ d[i];
            c  = (c << 1) & mask;
            if (fb) c = c ^ poly;
        end
        c = ~c & mask;
        for (int j = w - 1; j >= 0; j--) push_bit(c[j], j == 0);
    endtask

    task automatic set_pkt(input logic [63:0] d, input int len, input logic m16);
        pkt_data  = d;
        pkt_len   = LEN_W'(len);
        pkt_crc16 = m16;
        pkt_valid = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        int n  = 0;
        bit ok = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            n++;
            if (pkt_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        pkt_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: got timeout, expected pkt_ready", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n  = 0;
        bit ok = 0;
        while (!ok && n < 5000) begin
            @(negedge clk);
            n++;
            if (!busy && exp_q.size() == 0) ok = 1;
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_idle: got timeout with %0d bits pending, expected 0",
                     name, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pkt_ready"}, pkt_ready, 1);
        check({name, "_bit_valid"}, bit_valid, 0);
        check({name, "_bit_out"}, bit_out, 0);
        check({name, "_bit_last"}, bit_last, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
    endtask

    // Downstream ready: constant 1 or pseudo-random stalls.
    initial begin
        bit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bit_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops one expected bit per transfer and checks stall stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_b) begin
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                if (prev_stall) begin
                    stall_checks++;
                    check("stall_hold", {bit_valid, bit_out, bit_last}, prev_vec);
                end
                prev_stall = bit_valid && !bit_ready;
                prev_vec   = {1'b1, bit_out, bit_last};
                if (bit_valid && bit_ready) begin
                    xfer_cnt++;
                    if (after_last) begin
                        gap_cyc    = cyc - last_cyc;
                        after_last = 0;
                    end
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_bit: got bit %0b, expected no transfer", bit_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("bit_out", bit_out, e.b);
                        check("bit_last", bit_last, e.last);
                    end
                    if (bit_last) begin
                        last_cyc   = cyc;
                        after_last = 1;
                    end
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, base, n;
        rst_b     = 1'b1;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        pkt_len   = '0;
        pkt_crc16 = 1'b0;
        #1 rst_b = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;

        // ADDR0/ENDP0 token: 11 zeros then CRC5 bits 0,1,0,0,0.
        repeat (11) push_bit(1'b0, 1'b0);
        push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b0);
        push_bit(1'b0, 1'b0);
        push_bit(1'b0, 1'b0);
        push_bit(1'b0, 1'b1);
        d0 = done_cnt;
        set_pkt(64'h0, 11, 1'b0);
        wait_accept("tok");
        check("first_bit_latency", bit_valid, 1);
        wait_idle("tok");
        check("tok_done_once", done_cnt - d0, 1);

        // CRC16 with empty payload: 16 zero bits, busy for 16 cycles.
        repeat (15) push_bit(1'b0, 1'b0);
        push_bit(1'b0, 1'b1);
        busy_cnt = 0;
        set_pkt(64'hFFFF, 0, 1'b1);
        wait_accept("crc16_empty");
        wait_idle("crc16_empty");
        check("crc16_empty_busy", busy_cnt, 16);

        // Same CRC16 packet unstalled, then with random stalls.
        model_push(64'h0302_0100, 32, 1'b1);
        set_pkt(64'h0302_0100, 32, 1'b1);
        wait_accept("d32");
        wait_idle("d32");
        stall_mode   = 1;
        stall_checks = 0;
        base         = xfer_cnt;
        model_push(64'h0302_0100, 32, 1'b1);
        set_pkt(64'h0302_0100, 32, 1'b1);
        wait_accept("d32_stall");
        wait_idle("d32_stall");
        stall_mode = 0;
        check("d32_stall_count", xfer_cnt - base, 48);
        check("d32_stalls_seen", stall_checks > 0, 1);

        // Reset after 7 payload bits abandons the packet.
        d0   = done_cnt;
        base = xfer_cnt;
        model_push(64'hCAFE_F00D, 32, 1'b1);
        set_pkt(64'hCAFE_F00D, 32, 1'b1);
        wait_accept("rst_mid");
        n = 0;
        while (xfer_cnt < base + 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("rst_mid_reached", xfer_cnt - base, 7);
        #1 rst_b = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - d0, 0);
        model_push(64'h7A5, 11, 1'b0);
        set_pkt(64'h7A5, 11, 1'b0);
        wait_accept("after_rst");
        wait_idle("after_rst");

        // Over-length request is clamped to MAX_BITS.
        base = xfer_cnt;
        model_push(64'hDEAD_BEEF_0123_4567, MAX_BITS + 5, 1'b0);
        set_pkt(64'hDEAD_BEEF_0123_4567, MAX_BITS + 5, 1'b0);
        wait_accept("clamp");
        wait_idle("clamp");
        check("clamp_count", xfer_cnt - base, MAX_BITS + 5);

        // Two queued packets: second is offered while the first is in flight.
        d0 = done_cnt;
        model_push(64'h123, 11, 1'b0);
        model_push(64'hBEEF, 16, 1'b1);
        set_pkt(64'h123, 11, 1'b0);
        wait_accept("pair_a");
        set_pkt(64'hBEEF, 16, 1'b1);
        gap_cyc = -1;
        @(negedge clk);
        check("pair_ready_low", {busy, pkt_ready}, 2'b10);
        wait_accept("pair_b");
        wait_idle("pair_b");
        check("pair_gap", gap_cyc, GAP);
        check("pair_done", done_cnt - d0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_crc_serializer.md
Name: usb_crc_serializer

Overview:
- Parametrised USB transmit-side packet serializer with CRC generation.
- Accepts a parallel payload of programmable bit length plus a per-packet CRC mode: CRC5 for tokens, CRC16 for data packets.
- Shifts the payload out LSb-first, then appends the inverted CRC remainder MSb-first.
- Sits between the packet-assembly logic and the bit-stuffer/NRZI stage; a ready/valid handshake on both sides lets the bit-stuffer stall it.

Parameters:
- MAX_BITS, 64: maximum payload bits per packet. Valid range 11..1024.
- LEN_W, $clog2(MAX_BITS+1): width of pkt_len. Derived; do not override.

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- pkt_valid  input  1  payload offered
- pkt_ready  output  1  block can accept a payload
- pkt_data  input  MAX_BITS  payload; bit 0 is transmitted first
- pkt_len  input  LEN_W  number of payload bits to send, 0..MAX_BITS
- pkt_crc16  input  1  1 = CRC16 (poly 0x8005, 16 bits); 0 = CRC5 (poly 0x05, 5 bits)
- bit_out  output  1  serial bit
- bit_valid  output  1  bit_out is valid
- bit_ready  input  1  downstream accepts bit_out
- bit_last  output  1  marks the final CRC bit of the packet
- busy  output  1  packet in flight
- done  output  1  one-cycle pulse after the last CRC bit transfers

Behaviour:
- Reset (rst_b low, asynchronous):
  - state goes to IDLE; CRC register is set to all ones.
  - pkt_ready=1; bit_valid=0, bit_out=0, bit_last=0, busy=0, done=0.
  - Reset mid-packet abandons the packet with no done pulse.
- A transfer occurs on a clock edge where valid&&ready. bit_out, bit_last and bit_valid must hold stable while bit_valid&&!bit_ready.
- States: IDLE, DATA, CRC.
- IDLE:
  - pkt_ready=1.
  - On a pkt transfer: latch pkt_data, len and mode; preset CRC register to all ones (width per mode); clear the bit index.
  - Go to DATA if len>0, else go to CRC.
- DATA:
  - bit_valid=1; bit_out=data[idx].
  - On each bit transfer, update the CRC: fb = crc[MSb]^bit; crc = (crc<<1) ^ (fb ? poly : 0), truncated to the mode width.
  - After the transfer with idx==len-1, go to CRC and load the shift-out register with ~crc_next.
- CRC:
  - Shift out the inverted remainder MSb-first: 5 bits for CRC5, 16 bits for CRC16.
  - bit_last=1 on the final bit.
  - On the final bit transfer: go to IDLE; done=1 on the next cycle.
- Latency: first bit is valid in the cycle after pkt acceptance.
  - No stalls: a packet occupies len+5 (CRC5) or len+16 (CRC16) bit cycles.
  - One idle cycle (IDLE, pkt_ready=1) separates packets.
- busy=1 in DATA and CRC.
- pkt_len>MAX_BITS: clamped to MAX_BITS.
- pkt_len==0: CRC-only packet. CRC5 sends 5 bits; CRC16 sends 16 zero bits.
- Stalls: arbitrary-length bit_ready=0 in any state leaves CRC, index and outputs frozen.
- pkt_valid in DATA/CRC is ignored (pkt_ready=0); the payload is not consumed.
- Index counter width: $clog2(MAX_BITS); never wraps, since the exit condition is checked against the latched len.

Optional Feature:
- Macro: USB_CRC_BACK2BACK_EN.
- Defined:
  - pkt_ready is also asserted in CRC state during the cycle bit_last&&bit_ready.
  - A pkt transfer in that cycle loads the next packet directly, with no IDLE cycle.
  - done still pulses for the completed packet.
- Undefined: pkt_ready=1 only in IDLE, as described above.

Test Plan:
- CRC5, len=11, data=0 (ADDR0/ENDP0 token), bit_ready=1 -> 11 zero bits, then CRC bits 0,1,0,0,0; bit_last on the 16th bit; done pulses once.
- CRC16, len=0 -> 16 bits all 0 (inverted 0xFFFF); bit_last on the 16th; busy high exactly 16 cycles.
- CRC16, len=32, data=0x03020100 with random bit_ready stalls -> bit sequence identical to the unstalled run and to a software CRC16 model; outputs stable across every stall.
- Assert rst_b low mid-DATA after 7 bits -> all outputs at reset values immediately; the next packet's CRC matches the model (register re-preset).
- pkt_len=MAX_BITS+5, CRC5 -> exactly MAX_BITS payload bits plus 5 CRC bits sent.
- Two queued packets (CRC5 then CRC16):
  - Macro undefined: one-cycle gap between packets.
  - USB_CRC_BACK2BACK_EN defined: the second packet's first bit immediately follows the first packet's bit_last.
